// File: rtl/lsu_aligner.sv
`default_nettype none
// ============================================================================
// Module   : lsu_aligner
// Purpose  : Load/store lane alignment, byte enables and req/ack bus control
//            with misalignment exceptions and access-fault timeout.
// Revision : 1.0
// ============================================================================
module lsu_aligner #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   i_wr_data,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [2:0]        i_f3,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    output logic [XLEN-1:0]   o_rd,
    output logic              o_stall,
    output logic              o_ex_ld,
    output logic              o_ex_st,
    output logic              o_fault_ld,
    output logic              o_fault_st,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_be,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata,
    input  logic              i_mem_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic [TO_W-1:0] cnt;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [2:0]      lat_f3;
    logic            lat_we;

    logic            misaligned;
    logic            bad_size;
    logic            st_bad;
    logic            ld_bad;
    logic            start;
    logic            timeout_hit;
    logic            fault;
    logic            done;

    logic [1:0]       lat_size;
    logic [OFF_W-1:0] off;
    logic [NB-1:0]    be_mask;
    logic [NB-1:0]    be_shift;
    logic [XLEN-1:0]  wdata_rep;
    logic [XLEN-1:0]  rd_shift;
    logic [XLEN-1:0]  rd_ext;
    logic [XLEN-1:0]  bus_addr;

    // Request checks look at the live datapath inputs; only meaningful in IDLE.
    always_comb begin
        misaligned = 1'b0;
        case (i_f3[1:0])
            2'd1:    misaligned = i_addr[0];
            2'd2:    misaligned = |i_addr[1:0];
            2'd3:    misaligned = |i_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign bad_size    = (XLEN == 32) && (i_f3[1:0] == 2'd3);
    assign st_bad      = misaligned | bad_size;
    assign ld_bad      = st_bad | (i_f3 == 3'b111);
    assign start       = (state == S_IDLE) &&
                         (i_wr_en ? !st_bad : (i_rd_en && !ld_bad));
    assign timeout_hit = (TIMEOUT != 0) && (state == S_BUSY) &&
                         !i_mem_ack && (cnt == TO_LAST);
    assign fault       = (i_mem_ack & i_mem_err) | timeout_hit;
    assign done        = (state == S_BUSY) && (i_mem_ack || timeout_hit);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUSY;
            S_BUSY:  if (done)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_f3    <= '0;
            lat_we    <= 1'b0;
        end else begin
            if (start) begin
                lat_addr  <= i_addr;
                lat_wdata <= i_wr_data;
                lat_f3    <= i_f3;
                lat_we    <= i_wr_en;
            end
            if ((state == S_BUSY) && !done) begin
                cnt <= cnt + TO_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Lane steering is derived purely from the latched request.
    assign lat_size = lat_f3[1:0];
    assign off      = lat_addr[OFF_W-1:0];
    assign bus_addr = {lat_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign rd_shift = i_mem_rdata >> {off, 3'b000};
    assign be_shift = be_mask << off;

    always_comb begin
        be_mask   = '1;
        wdata_rep = lat_wdata;
        case (lat_size)
            2'd0: begin
                be_mask   = NB'(1);
                wdata_rep = {NB{lat_wdata[7:0]}};
            end
            2'd1: begin
                be_mask   = NB'(3);
                wdata_rep = {(NB/2){lat_wdata[15:0]}};
            end
            2'd2: begin
                be_mask   = NB'(15);
                wdata_rep = {(NB/4){lat_wdata[31:0]}};
            end
            default: begin
                be_mask   = '1;
                wdata_rep = lat_wdata;
            end
        endcase
    end

    always_comb begin
        rd_ext = rd_shift;
        case (lat_size)
            2'd0: begin
                if (lat_f3[2]) rd_ext = XLEN'(rd_shift[7:0]);
                else           rd_ext = XLEN'($signed(rd_shift[7:0]));
            end
            2'd1: begin
                if (lat_f3[2]) rd_ext = XLEN'(rd_shift[15:0]);
                else           rd_ext = XLEN'($signed(rd_shift[15:0]));
            end
            2'd2: begin
                if (lat_f3[2]) rd_ext = XLEN'(rd_shift[31:0]);
                else           rd_ext = XLEN'($signed(rd_shift[31:0]));
            end
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        o_stall     = 1'b0;
        o_ex_ld     = 1'b0;
        o_ex_st     = 1'b0;
        o_fault_ld  = 1'b0;
        o_fault_st  = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        o_rd        = '0;
        case (state)
            S_IDLE: begin
                o_stall = start;
                o_ex_st = i_wr_en & st_bad;
                o_ex_ld = ~i_wr_en & i_rd_en & ld_bad;
            end
            S_BUSY: begin
                o_stall     = ~done;
                o_mem_req   = 1'b1;
                o_mem_we    = lat_we;
                o_mem_addr  = bus_addr;
                o_mem_wdata = wdata_rep;
                o_mem_be    = be_shift;
                o_fault_ld  = ~lat_we & fault;
                o_fault_st  = lat_we & fault;
                if (i_mem_ack && !i_mem_err && !lat_we) o_rd = rd_ext;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_aligner
// Purpose  : Self-checking bench for lsu_aligner, XLEN=32 and XLEN=64 builds.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lsu_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // sel picks which instance receives requests/acks: 0 -> XLEN=32, 1 -> XLEN=64
    logic        sel;
    logic        rst_n;
    logic [63:0] wr_data, addr, rdata;
    logic [2:0]  f3;
    logic        wr_en, rd_en, ack, err;

    logic [31:0] a_rd, a_maddr, a_wdata;
    logic [3:0]  a_be;
    logic        a_stall, a_ex_ld, a_ex_st, a_f_ld, a_f_st, a_req, a_we;
    logic [63:0] b_rd, b_maddr, b_wdata;
    logic [7:0]  b_be;
    logic        b_stall, b_ex_ld, b_ex_st, b_f_ld, b_f_st, b_req, b_we;

    lsu_aligner #(.XLEN(32), .TIMEOUT(4), .TO_W(3)) u_a (
        .i_clk(clk), .i_rst(rst_n),
        .i_wr_data(wr_data[31:0]), .i_addr(addr[31:0]), .i_f3(f3),
        .i_wr_en(wr_en & ~sel), .i_rd_en(rd_en & ~sel),
        .o_rd(a_rd), .o_stall(a_stall), .o_ex_ld(a_ex_ld), .o_ex_st(a_ex_st),
        .o_fault_ld(a_f_ld), .o_fault_st(a_f_st),
        .o_mem_req(a_req), .o_mem_we(a_we), .o_mem_addr(a_maddr),
        .o_mem_wdata(a_wdata), .o_mem_be(a_be),
        .i_mem_ack(ack & ~sel), .i_mem_rdata(rdata[31:0]), .i_mem_err(err)
    );

    lsu_aligner #(.XLEN(64), .TIMEOUT(8), .TO_W(4)) u_b (
        .i_clk(clk), .i_rst(rst_n),
        .i_wr_data(wr_data), .i_addr(addr), .i_f3(f3),
        .i_wr_en(wr_en & sel), .i_rd_en(rd_en & sel),
        .o_rd(b_rd), .o_stall(b_stall), .o_ex_ld(b_ex_ld), .o_ex_st(b_ex_st),
        .o_fault_ld(b_f_ld), .o_fault_st(b_f_st),
        .o_mem_req(b_req), .o_mem_we(b_we), .o_mem_addr(b_maddr),
        .o_mem_wdata(b_wdata), .o_mem_be(b_be),
        .i_mem_ack(ack & sel), .i_mem_rdata(rdata), .i_mem_err(err)
    );

    logic [63:0] rd, maddr, wdata;
    logic [7:0]  be;
    logic        stall, ex_ld, ex_st, f_ld, f_st, req, we;

    always_comb begin
        if (sel) begin
            rd = b_rd; maddr = b_maddr; wdata = b_wdata; be = b_be;
            stall = b_stall; ex_ld = b_ex_ld; ex_st = b_ex_st;
            f_ld = b_f_ld; f_st = b_f_st; req = b_req; we = b_we;
        end else begin
            rd = {32'b0, a_rd}; maddr = {32'b0, a_maddr}; wdata = {32'b0, a_wdata};
            be = {4'b0, a_be};
            stall = a_stall; ex_ld = a_ex_ld; ex_st = a_ex_st;
            f_ld = a_f_ld; f_st = a_f_st; req = a_req; we = a_we;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic m_exc(input int xl, input logic [2:0] f,
                                   input logic [63:0] a, input logic is_ld);
        int n;
        n = 1 << f[1:0];
        if ((int'(a[2:0]) % n) != 0) return 1'b1;
        if (xl == 32 && f[1:0] == 2'd3) return 1'b1;
        if (is_ld && f == 3'b111) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_be(input int xl, input logic [1:0] sz,
                                        input logic [63:0] a);
        int off;
        int n;
        logic [15:0] m;
        off = int'(a[2:0]) % (xl / 8);
        n = 1 << sz;
        m = 16'((32'd1 << n) - 1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input int xl, input logic [1:0] sz,
                                            input logic [63:0] d);
        logic [63:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        if (xl == 32) r[63:32] = '0;
        return r;
    endfunction

    function automatic logic [63:0] m_rd(input int xl, input logic [2:0] f,
                                         input logic [63:0] a, input logic [63:0] bus);
        logic [63:0] v, mask;
        int off, bits;
        if (xl == 32) bus[63:32] = '0;
        off  = int'(a[2:0]) % (xl / 8);
        bits = 8 << f[1:0];
        v    = bus >> (8 * off);
        mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        v    = v & mask;
        if (!f[2] && v[bits-1]) v = v | ~mask;
        if (xl == 32) v[63:32] = '0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; ack = 1'b0; err = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(); tick();
        @(negedge clk);
        if ({a_req, a_we, a_be, a_stall, a_f_ld, a_f_st} !== 9'b0) begin
            fails++; $display("FAIL reset_a got=%b exp=0", {a_req, a_we, a_be, a_stall, a_f_ld, a_f_st});
        end
        tests++;
        if ({b_req, b_we, b_be, b_stall, b_f_ld, b_f_st} !== 13'b0) begin
            fails++; $display("FAIL reset_b got=%b exp=0", {b_req, b_we, b_be, b_stall, b_f_ld, b_f_st});
        end
        tests++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb32();
        sel = 1'b0; rd_en = 1'b1; f3 = 3'b000; addr = 64'h1003;
        rdata = 64'hA5A5_A5A5_80FF_FF00;
        for (int k = 0; k < 5; k++) begin
            ack = (k == 4);
            @(negedge clk);
            if (stall !== (k < 4)) begin
                fails++; $display("FAIL lb_stall k=%0d got=%b exp=%b", k, stall, (k < 4));
            end
            tests++;
            if (k > 0 && {req, maddr, be} !== {1'b1, 64'h1000, 8'h08}) begin
                fails++; $display("FAIL lb_bus k=%0d got=%b/%h/%h", k, req, maddr, be);
            end
            if (k > 0) tests++;
            if (rd !== ((k == 4) ? 64'h0000_0000_FFFF_FF80 : 64'h0)) begin
                fails++; $display("FAIL lb_rd k=%0d got=%h", k, rd);
            end
            tests++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sh32();
        sel = 1'b0; wr_en = 1'b1; f3 = 3'b001; addr = 64'h2002; wr_data = 64'h1234_ABCD;
        for (int k = 0; k < 3; k++) begin
            ack = (k == 2);
            @(negedge clk);
            if (k > 0 && {req, we, be, wdata} !== {1'b1, 1'b1, 8'h0C, 64'hABCD_ABCD}) begin
                fails++; $display("FAIL sh_bus k=%0d got=%b/%b/%h/%h exp=1/1/0c/abcdabcd", k, req, we, be, wdata);
            end
            if (k > 0) tests++;
            if (stall !== (k < 2)) begin
                fails++; $display("FAIL sh_stall k=%0d got=%b", k, stall);
            end
            tests++;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        if ({req, we, be, maddr, wdata} !== '0) begin
            fails++; $display("FAIL idle_bus got=%b/%b/%h/%h/%h exp=0", req, we, be, maddr, wdata);
        end
        tests++;
    endtask

    task automatic test_lwu64();
        logic [63:0] exp;
        sel = 1'b1; addr = 64'h4; rdata = 64'h8765_4321_0000_0000;
        for (int r = 0; r < 2; r++) begin
            f3 = (r == 0) ? 3'b110 : 3'b010;
            rd_en = 1'b1; ack = 1'b0;
            @(negedge clk);
            tick();
            ack = 1'b1;
            @(negedge clk);
            exp = (r == 0) ? 64'h0000_0000_8765_4321 : 64'hFFFF_FFFF_8765_4321;
            if ({rd, be, stall} !== {exp, 8'hF0, 1'b0}) begin
                fails++; $display("FAIL lw64 f3=%b got=%h/%h/%b exp=%h/f0/0", f3, rd, be, stall, exp);
            end
            tests++;
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_exceptions();
        sel = 1'b0; rd_en = 1'b1; f3 = 3'b010; addr = 64'h1002;
        @(negedge clk);
        if ({ex_ld, ex_st, stall, req} !== 4'b1000) begin
            fails++; $display("FAIL ex_lw got=%b exp=1000", {ex_ld, ex_st, stall, req});
        end
        tests++;
        tick();
        @(negedge clk);
        if ({stall, req} !== 2'b00) begin
            fails++; $display("FAIL ex_lw_hold got=%b exp=00", {stall, req});
        end
        tests++;
        tick(); idle_inputs();

        wr_en = 1'b1; f3 = 3'b011; addr = 64'h8;
        @(negedge clk);
        if ({ex_ld, ex_st, stall, req} !== 4'b0100) begin
            fails++; $display("FAIL ex_sd32 got=%b exp=0100", {ex_ld, ex_st, stall, req});
        end
        tests++;
        tick(); idle_inputs();

        sel = 1'b1; rd_en = 1'b1; f3 = 3'b111; addr = 64'h0;
        @(negedge clk);
        if ({ex_ld, ex_st, stall, req} !== 4'b1000) begin
            fails++; $display("FAIL ex_ldu got=%b exp=1000", {ex_ld, ex_st, stall, req});
        end
        tests++;
        tick(); idle_inputs();

        wr_en = 1'b1; rd_en = 1'b1; f3 = 3'b001; addr = 64'h1;
        @(negedge clk);
        if ({ex_ld, ex_st, stall, req} !== 4'b0100) begin
            fails++; $display("FAIL ex_both got=%b exp=0100", {ex_ld, ex_st, stall, req});
        end
        tests++;
        tick(); idle_inputs();

        // store wins even when the load encoding alone would trap
        wr_en = 1'b1; rd_en = 1'b1; f3 = 3'b111; addr = 64'h0; wr_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        if ({ex_ld, ex_st, stall, req} !== 4'b0010) begin
            fails++; $display("FAIL prio_start got=%b exp=0010", {ex_ld, ex_st, stall, req});
        end
        tests++;
        tick();
        ack = 1'b1;
        @(negedge clk);
        if ({we, f_st, f_ld, rd, wdata} !== {3'b100, 64'h0, 64'h0123_4567_89AB_CDEF}) begin
            fails++; $display("FAIL prio_store got=%b/%b/%b/%h/%h", we, f_st, f_ld, rd, wdata);
        end
        tests++;
        tick(); idle_inputs();
    endtask

    task automatic test_timeout();
        int  req_cycles;
        int  pulses;
        bit  seen;
        logic stall_at_fault;
        req_cycles = 0; pulses = 0; seen = 0; stall_at_fault = 1'b1;
        sel = 1'b0; wr_en = 1'b1; f3 = 3'b010; addr = 64'h10; wr_data = 64'hDEAD_BEEF;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (req) req_cycles++;
            if (f_st) begin pulses++; seen = 1; stall_at_fault = stall; end
            tick();
        end
        if (!seen) begin
            fails++; $display("FAIL to_expire got=no_fault exp=fault");
        end
        tests++;
        wr_en = 1'b0; ack = 1'b1;
        @(negedge clk);
        if (f_st) pulses++;
        if ({req_cycles, pulses} !== {32'd4, 32'd1}) begin
            fails++; $display("FAIL to_count req_cycles=%0d pulses=%0d exp=4/1", req_cycles, pulses);
        end
        tests++;
        if ({stall_at_fault, req, stall, rd} !== 67'b0) begin
            fails++; $display("FAIL to_idle got=%b/%b/%b/%h exp=0", stall_at_fault, req, stall, rd);
        end
        tests++;
        tick(); idle_inputs();
    endtask

    task automatic test_bus_err();
        sel = 1'b1; rd_en = 1'b1; f3 = 3'b011; addr = 64'h18; rdata = {$urandom, $urandom};
        @(negedge clk);
        tick();
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        if ({f_ld, f_st, stall, rd} !== {3'b100, 64'h0}) begin
            fails++; $display("FAIL err_ld got=%b/%b/%b/%h exp=1/0/0/0", f_ld, f_st, stall, rd);
        end
        tests++;
        tick(); idle_inputs();
        @(negedge clk);
        if (f_ld !== 1'b0) begin
            fails++; $display("FAIL err_pulse got=%b exp=0", f_ld);
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        sel = 1'b1; wr_en = 1'b1; f3 = 3'b011; addr = 64'h40; wr_data = {$urandom, $urandom};
        tick();
        @(negedge clk);
        if (req !== 1'b1) begin
            fails++; $display("FAIL rst_mid_busy got=%b exp=1", req);
        end
        tests++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; wr_en = 1'b0; ack = 1'b1;
        @(negedge clk);
        if ({req, f_st, f_ld, stall} !== 4'b0) begin
            fails++; $display("FAIL rst_mid got=%b exp=0000", {req, f_st, f_ld, stall});
        end
        tests++;
        tick(); idle_inputs();
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int          xl, lat;
            logic        st, e, both;
            logic [63:0] exp_rd, exp_addr;
            sel  = 1'($urandom_range(0, 1));
            xl   = sel ? 64 : 32;
            st   = 1'($urandom_range(0, 1));
            both = st && ($urandom_range(0, 3) == 0);
            f3   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
            wr_data = {$urandom, $urandom};
            rdata   = {$urandom, $urandom};
            lat = $urandom_range(0, 3);
            e   = ($urandom_range(0, 5) == 0);
            wr_en = st; rd_en = !st || both;
            @(negedge clk);
            if (m_exc(xl, f3, addr, !st)) begin
                if ({ex_st, ex_ld, stall, req} !== {st, !st, 2'b00}) begin
                    fails++; $display("FAIL rnd_ex it=%0d got=%b exp=%b", it, {ex_st, ex_ld, stall, req}, {st, !st, 2'b00});
                end
                tests++;
                tick(); idle_inputs();
                continue;
            end
            if ({ex_st, ex_ld, stall, req} !== 4'b0010) begin
                fails++; $display("FAIL rnd_start it=%0d got=%b exp=0010", it, {ex_st, ex_ld, stall, req});
            end
            tests++;
            tick();
            exp_addr = addr & ~64'(xl / 8 - 1);
            if (xl == 32) exp_addr[63:32] = '0;
            for (int k = 0; k <= lat; k++) begin
                ack = (k == lat); err = (k == lat) && e;
                @(negedge clk);
                if ({req, we, maddr, be} !== {1'b1, st, exp_addr, m_be(xl, f3[1:0], addr)}) begin
                    fails++; $display("FAIL rnd_bus it=%0d got=%b/%b/%h/%h exp=1/%b/%h/%h", it, req, we, maddr, be,
                                      st, exp_addr, m_be(xl, f3[1:0], addr));
                end
                tests++;
                if (st && wdata !== m_wdata(xl, f3[1:0], wr_data)) begin
                    fails++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", it, wdata, m_wdata(xl, f3[1:0], wr_data));
                end
                if (st) tests++;
                exp_rd = (k == lat && !st && !e) ? m_rd(xl, f3, addr, rdata) : 64'h0;
                if (rd !== exp_rd) begin
                    fails++; $display("FAIL rnd_rd it=%0d f3=%b addr=%h got=%h exp=%h", it, f3, addr, rd, exp_rd);
                end
                tests++;
                if ({stall, f_ld, f_st} !== {k != lat, (k == lat) && e && !st, (k == lat) && e && st}) begin
                    fails++; $display("FAIL rnd_ctl it=%0d k=%0d got=%b", it, k, {stall, f_ld, f_st});
                end
                tests++;
                tick();
            end
            idle_inputs();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst_n = 1'b0; f3 = 3'b0; addr = '0; wr_data = '0; rdata = '0;
        idle_inputs();
        test_reset();
        test_lb32();
        test_sh32();
        test_lwu64();
        test_exceptions();
        test_timeout();
        test_bus_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
